// File: rtl/board_id_pkg.sv
// Shared state encoding and constants for the board ID allocator.
package board_id_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_LISTEN = 3'd1;
    localparam state_t ST_CLAIM  = 3'd2;
    localparam state_t ST_LOCKED = 3'd3;
    localparam state_t ST_FULL   = 3'd4;

    localparam int ID_NONE = 0;

    // Bits needed to hold the values 0..n-1.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/board_id_occupancy.sv
// Peer ID occupancy bitmap with lowest-free-ID encoder.
// Define ID_AGEING_EN to free IDs that have not been reported for AGE_CYC cycles.
module board_id_occupancy
    import board_id_pkg::*;
#(
    parameter int MAX_BOARDS = 4,
    parameter int ID_W       = 8,
    parameter int N_EXT      = 3,
    parameter int AGE_CYC    = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic [N_EXT*ID_W-1:0] ext_id,
    input  logic [N_EXT-1:0]      ext_valid,
    output logic [MAX_BOARDS-1:0] occupied,
    output logic                  any_free,
    output logic [ID_W-1:0]       lowest_free,
    output logic                  freed
);

    if (AGE_CYC < 1) begin : g_bad_age
        $error("AGE_CYC must be at least 1");
    end

    logic [MAX_BOARDS-1:0] report;
    logic [MAX_BOARDS-1:0] occ_d;
    logic [MAX_BOARDS-1:0] occ_q;

    always_comb begin
        report = '0;
        for (int s = 0; s < N_EXT; s++) begin
            for (int k = 0; k < MAX_BOARDS; k++) begin
                if (ext_valid[s] && ext_id[s*ID_W +: ID_W] == ID_W'(k + 1)) begin
                    report[k] = 1'b1;
                end
            end
        end
    end

`ifdef ID_AGEING_EN
    localparam int AGE_W = cnt_width(AGE_CYC);

    logic [AGE_W-1:0]      age_d [MAX_BOARDS];
    logic [AGE_W-1:0]      age_q [MAX_BOARDS];
    logic [MAX_BOARDS-1:0] expire;

    // A reported ID restarts its silence timer; an occupied ID whose timer ran out is dropped.
    always_comb begin
        for (int k = 0; k < MAX_BOARDS; k++) begin
            expire[k] = occ_q[k] && !report[k] && (age_q[k] == '0);
            if (clr) begin
                age_d[k] = '0;
            end else if (report[k]) begin
                age_d[k] = AGE_W'(AGE_CYC - 1);
            end else if (age_q[k] != '0) begin
                age_d[k] = age_q[k] - 1'b1;
            end else begin
                age_d[k] = age_q[k];
            end
        end
        occ_d = clr ? '0 : ((occ_q & ~expire) | report);
        freed = !clr && (|expire);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < MAX_BOARDS; k++) begin
                age_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < MAX_BOARDS; k++) begin
                age_q[k] <= age_d[k];
            end
        end
    end
`else
    always_comb begin
        occ_d = clr ? '0 : (occ_q | report);
        freed = 1'b0;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    // The choice sees this cycle's reports as well as the stored bitmap.
    always_comb begin
        any_free    = 1'b0;
        lowest_free = ID_W'(ID_NONE);
        for (int k = MAX_BOARDS - 1; k >= 0; k--) begin
            if (!occ_d[k]) begin
                any_free    = 1'b1;
                lowest_free = ID_W'(k + 1);
            end
        end
    end

    assign occupied = occ_q;

endmodule

// File: rtl/board_id_alloc.sv
// Board ID allocator: listens to peer reports, claims the lowest free ID, backs off on collision.
// release_req drops the own ID and aborts; ID_AGEING_EN enables ageing of peer IDs.
module board_id_alloc
    import board_id_pkg::*;
#(
    parameter int MAX_BOARDS = 4,
    parameter int ID_W       = 8,
    parameter int N_EXT      = 3,
    parameter int LISTEN_CYC = 16,
    parameter int CLAIM_CYC  = 8,
    parameter int MAX_RETRY  = 3,
    parameter int AGE_CYC    = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  lock_id_en,
    input  logic                  release_req,
    input  logic [N_EXT*ID_W-1:0] ext_id,
    input  logic [N_EXT-1:0]      ext_valid,
    output logic [ID_W-1:0]       board_id,
    output logic                  id_locked,
    output logic                  id_busy,
    output logic                  announce,
    output logic                  no_free_id,
    output logic                  id_conflict,
    output logic [MAX_BOARDS-1:0] occupied
);

    if (LISTEN_CYC < 1 || CLAIM_CYC < 1 || MAX_RETRY < 1 || MAX_BOARDS < 1) begin : g_bad_param
        $error("LISTEN_CYC, CLAIM_CYC, MAX_RETRY and MAX_BOARDS must be at least 1");
    end

    localparam int CNT_MAX = (LISTEN_CYC > CLAIM_CYC) ? LISTEN_CYC : CLAIM_CYC;
    localparam int CNT_W   = cnt_width(CNT_MAX);
    localparam int RTY_W   = cnt_width(MAX_RETRY + 1);

    state_t           state_d, state_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic [ID_W-1:0]  cand_d, cand_q;
    logic [RTY_W-1:0] retry_d, retry_q;

    logic [ID_W-1:0]  board_id_d, board_id_q;
    logic             id_locked_d, id_locked_q;
    logic             id_busy_d, id_busy_q;
    logic             announce_d, announce_q;
    logic             no_free_id_d, no_free_id_q;
    logic             id_conflict_d, id_conflict_q;

    logic             any_free;
    logic [ID_W-1:0]  lowest_free;
    logic             freed;
    logic             hit_cand;
    logic             hit_own;

    board_id_occupancy #(
        .MAX_BOARDS (MAX_BOARDS),
        .ID_W       (ID_W),
        .N_EXT      (N_EXT),
        .AGE_CYC    (AGE_CYC)
    ) u_occ (
        .clk         (clk),
        .rst         (rst),
        .clr         (release_req),
        .ext_id      (ext_id),
        .ext_valid   (ext_valid),
        .occupied    (occupied),
        .any_free    (any_free),
        .lowest_free (lowest_free),
        .freed       (freed)
    );

    always_comb begin
        hit_cand = 1'b0;
        hit_own  = 1'b0;
        for (int s = 0; s < N_EXT; s++) begin
            if (ext_valid[s] && ext_id[s*ID_W +: ID_W] == cand_q) begin
                hit_cand = 1'b1;
            end
            if (ext_valid[s] && ext_id[s*ID_W +: ID_W] == board_id_q) begin
                hit_own = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cand_d  = cand_q;
        retry_d = retry_q;
        if (release_req) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            retry_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (lock_id_en) begin
                        state_d = ST_LISTEN;
                        cnt_d   = CNT_W'(LISTEN_CYC - 1);
                    end
                end
                ST_LISTEN: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - 1'b1;
                    end else if (any_free) begin
                        state_d = ST_CLAIM;
                        cand_d  = lowest_free;
                        cnt_d   = CNT_W'(CLAIM_CYC - 1);
                    end else begin
                        state_d = ST_FULL;
                    end
                end
                ST_CLAIM: begin
                    // A contested candidate is already marked taken by the peer report itself.
                    if (hit_cand) begin
                        retry_d = retry_q + 1'b1;
                        if (int'(retry_q) + 1 >= MAX_RETRY) begin
                            state_d = ST_FULL;
                        end else begin
                            state_d = ST_LISTEN;
                            cnt_d   = CNT_W'(LISTEN_CYC - 1);
                        end
                    end else if (cnt_q != '0) begin
                        cnt_d = cnt_q - 1'b1;
                    end else begin
                        state_d = ST_LOCKED;
                    end
                end
                ST_LOCKED: begin
                    state_d = ST_LOCKED;
                end
                ST_FULL: begin
                    if (freed && lock_id_en) begin
                        state_d = ST_LISTEN;
                        cnt_d   = CNT_W'(LISTEN_CYC - 1);
                        retry_d = '0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Outputs are a registered view of the current state; release clears them at the same edge.
    always_comb begin
        board_id_d    = ID_W'(ID_NONE);
        id_locked_d   = 1'b0;
        id_busy_d     = 1'b0;
        announce_d    = 1'b0;
        no_free_id_d  = 1'b0;
        id_conflict_d = 1'b0;
        if (!release_req) begin
            if (state_q == ST_LOCKED) begin
                board_id_d  = cand_q;
                id_locked_d = 1'b1;
                announce_d  = !id_locked_q;
            end
            id_busy_d     = (state_q == ST_LISTEN) || (state_q == ST_CLAIM);
            no_free_id_d  = (state_q == ST_FULL);
            id_conflict_d = id_conflict_q || (id_locked_q && hit_own);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            cand_q        <= ID_W'(ID_NONE);
            retry_q       <= '0;
            board_id_q    <= ID_W'(ID_NONE);
            id_locked_q   <= 1'b0;
            id_busy_q     <= 1'b0;
            announce_q    <= 1'b0;
            no_free_id_q  <= 1'b0;
            id_conflict_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            cand_q        <= cand_d;
            retry_q       <= retry_d;
            board_id_q    <= board_id_d;
            id_locked_q   <= id_locked_d;
            id_busy_q     <= id_busy_d;
            announce_q    <= announce_d;
            no_free_id_q  <= no_free_id_d;
            id_conflict_q <= id_conflict_d;
        end
    end

    assign board_id    = board_id_q;
    assign id_locked   = id_locked_q;
    assign id_busy     = id_busy_q;
    assign announce    = announce_q;
    assign no_free_id  = no_free_id_q;
    assign id_conflict = id_conflict_q;

endmodule
